// File: rtl/axi_rd_slave_pkg.sv
// Shared types and constants for the AXI4 read-channel responder.
//   ADDR_W / DATA_W / LEN_W / SIZE_W : channel field widths
//   BURST_* / RESP_*                 : ARBURST and RRESP encodings
//   state_e                          : responder FSM states
//   burst_cfg_t                      : latched burst shape (len, size, burst)
//   burst_illegal()                  : burst-wide SLVERR condition
package axi_rd_slave_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned SIZE_W = 3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
        logic [1:0]        burst;
    } burst_cfg_t;

    // Beats wider than the 64-bit bus, the reserved burst type, and WRAP
    // lengths other than 2/4/8/16 beats fail every beat of the burst.
    function automatic logic burst_illegal(burst_cfg_t cfg);
        logic wrap_len_ok;
        wrap_len_ok = (cfg.len == LEN_W'(1)) || (cfg.len == LEN_W'(3)) ||
                      (cfg.len == LEN_W'(7)) || (cfg.len == LEN_W'(15));
        return (cfg.size > SIZE_W'(3)) ||
               (cfg.burst == BURST_RSVD) ||
               ((cfg.burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/axi_rd_slave_burst_addr.sv
// Combinational next-beat address generator.
//   addr        : current beat byte address
//   size        : log2 bytes per beat
//   len         : burst length minus one
//   burst       : burst type (FIXED / INCR / WRAP)
//   next_addr_c : byte address of the following beat
module axi_rd_slave_burst_addr
    import axi_rd_slave_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [SIZE_W-1:0] size,
    input  logic [LEN_W-1:0]  len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr_c
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;

    // WRAP keeps the upper bits and lets the low bits roll over inside an
    // aligned window of (len+1)*step bytes.
    always_comb begin
        step        = ADDR_W'(1) << size;
        incr_addr   = addr + step;
        wrap_mask   = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        next_addr_c = addr;
        case (burst)
            BURST_INCR: next_addr_c = incr_addr;
            BURST_WRAP: next_addr_c = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    next_addr_c = addr;
        endcase
    end

endmodule

// File: rtl/axi_rd_slave.sv
// AXI4 read-channel responder backed by a memory with a 1-cycle registered
// read port. One outstanding burst; one 64-bit beat per request address.
//   clk, rst            : clock, asynchronous active-high reset
//   AR*                 : read address channel (ARPORT is ignored)
//   R*                  : read data channel
//   mem_ren, mem_addr   : backing read strobe and 8-byte aligned address
//   mem_rdata           : backing data, valid the cycle after mem_ren
module axi_rd_slave
    import axi_rd_slave_pkg::*;
#(
    parameter int unsigned       ID_W     = 4,
    parameter logic [ADDR_W-1:0] MEM_BASE = 64'h0000_0000_8000_0000,
    parameter logic [ADDR_W-1:0] MEM_SIZE = 64'h0000_0000_0800_0000
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic [SIZE_W-1:0] ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic [2:0]        ARPORT,
    input  logic              ARVALID,
    output logic              ARREADY,

    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,

    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    burst_cfg_t         cfg_q, cfg_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [1:0]         beat_resp_q, beat_resp_d;

    logic               arready_d;
    logic [ID_W-1:0]    rid_d;
    logic [DATA_W-1:0]  rdata_d;
    logic [1:0]         rresp_d;
    logic               rlast_d;
    logic               rvalid_d;
    logic               mem_ren_d;
    logic [ADDR_W-1:0]  mem_addr_d;

    logic               enter_fetch;
    logic [1:0]         fetch_resp;
    logic [ADDR_W-1:0]  next_addr_c;

    // Protection bits carry no meaning for this memory.
    logic unused_arport;
    assign unused_arport = ^ARPORT;

    axi_rd_slave_burst_addr u_burst_addr (
        .addr        (addr_q),
        .size        (cfg_q.size),
        .len         (cfg_q.len),
        .burst       (cfg_q.burst),
        .next_addr_c (next_addr_c)
    );

    // Offset form avoids overflow of MEM_BASE+MEM_SIZE near the top of the map.
    function automatic logic in_range(logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - MEM_BASE;
        return (a >= MEM_BASE) && (off < MEM_SIZE);
    endfunction

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        cfg_d       = cfg_q;
        beat_cnt_d  = beat_cnt_q;
        beat_resp_d = beat_resp_q;
        rid_d       = RID;
        rdata_d     = RDATA;
        rresp_d     = RRESP;
        rlast_d     = RLAST;
        rvalid_d    = RVALID;
        mem_ren_d   = 1'b0;
        mem_addr_d  = mem_addr;
        enter_fetch = 1'b0;
        fetch_resp  = RESP_OKAY;

        case (state_q)
            IDLE: begin
                if (ARVALID) begin
                    id_d        = ARID;
                    addr_d      = ARADDR;
                    cfg_d.len   = ARLEN;
                    cfg_d.size  = ARSIZE;
                    cfg_d.burst = ARBURST;
                    beat_cnt_d  = ARLEN;
                    enter_fetch = 1'b1;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                state_d = RESP;
            end
            RESP: begin
                // First RESP cycle has RVALID low: memory data lands this cycle.
                if (!RVALID) begin
                    rvalid_d = 1'b1;
                    rdata_d  = (beat_resp_q == RESP_OKAY) ? mem_rdata : '0;
                    rresp_d  = beat_resp_q;
                    rlast_d  = (beat_cnt_q == '0);
                    rid_d    = id_q;
                end else if (RREADY) begin
                    rvalid_d = 1'b0;
                    if (RLAST) begin
                        state_d = IDLE;
                    end else begin
                        addr_d      = next_addr_c;
                        beat_cnt_d  = beat_cnt_q - LEN_W'(1);
                        enter_fetch = 1'b1;
                        state_d     = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Classify the beat about to be fetched; only OKAY beats touch memory.
        if (enter_fetch) begin
            if (burst_illegal(cfg_d)) begin
                fetch_resp = RESP_SLVERR;
            end else if (!in_range(addr_d)) begin
                fetch_resp = RESP_DECERR;
            end else begin
                fetch_resp = RESP_OKAY;
            end
            beat_resp_d = fetch_resp;
            if (fetch_resp == RESP_OKAY) begin
                mem_ren_d  = 1'b1;
                mem_addr_d = addr_d & ~ADDR_W'(7);
            end
        end

        arready_d = (state_d == IDLE);
    end

    // State, burst context and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            cfg_q       <= '0;
            beat_cnt_q  <= '0;
            beat_resp_q <= RESP_OKAY;
            ARREADY     <= 1'b1;
            RID         <= '0;
            RDATA       <= '0;
            RRESP       <= RESP_OKAY;
            RLAST       <= 1'b0;
            RVALID      <= 1'b0;
            mem_ren     <= 1'b0;
            mem_addr    <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            cfg_q       <= cfg_d;
            beat_cnt_q  <= beat_cnt_d;
            beat_resp_q <= beat_resp_d;
            ARREADY     <= arready_d;
            RID         <= rid_d;
            RDATA       <= rdata_d;
            RRESP       <= rresp_d;
            RLAST       <= rlast_d;
            RVALID      <= rvalid_d;
            mem_ren     <= mem_ren_d;
            mem_addr    <= mem_addr_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed bench for axi_rd_slave: expected beats are queued when an AR is
// issued and compared as R beats are accepted; a memory model records reads.
module tb_axi_rd_slave;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] LIMIT = 64'h0000_0000_8800_0000;

    typedef struct packed {
        logic [63:0] addr;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ARID;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [2:0]  ARPORT;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_ren;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata = 64'h0;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          hs_cyc   = 0;
    int          seen_cyc = 0;
    beat_t       sb[$];
    logic [63:0] mem_log[$];

    axi_rd_slave dut (
        .clk       (clk),
        .rst       (rst),
        .ARID      (ARID),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .ARPORT    (ARPORT),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RID       (RID),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_word(logic [63:0] a);
        return {~a[31:0], a[31:0]} ^ 64'h1234_5678_9abc_def0;
    endfunction

    // Registered memory port: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_ren === 1'b1) begin
            mem_rdata <= mem_word(mem_addr);
            mem_log.push_back(mem_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bench-side reference for the beat address sequence and responses.
    task automatic expect_burst(input logic [3:0] id, input logic [63:0] addr,
                                input int len, input int size, input logic [1:0] burst);
        logic [63:0] a;
        logic [63:0] step;
        logic [63:0] bound;
        logic [63:0] wbase;
        logic        err;
        beat_t       e;
        a     = addr;
        step  = 64'd1 << size;
        bound = 64'(len + 1) * step;
        err   = (size > 3) || (burst == 2'b11) ||
                ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
        for (int b = 0; b <= len; b++) begin
            e.addr = a;
            e.id   = id;
            e.last = (b == len);
            if (err)                          e.resp = 2'b10;
            else if (a >= BASE && a < LIMIT)  e.resp = 2'b00;
            else                              e.resp = 2'b11;
            sb.push_back(e);
            if (burst == 2'b01) begin
                a = a + step;
            end else if (burst == 2'b10 && !err) begin
                wbase = a - (a % bound);
                a     = wbase + ((a - wbase + step) % bound);
            end
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [63:0] addr,
                           input int len, input int size, input logic [1:0] burst);
        expect_burst(id, addr, len, size, burst);
        ARID    = id;
        ARADDR  = addr;
        ARLEN   = 8'(len);
        ARSIZE  = 3'(size);
        ARBURST = burst;
        ARVALID = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (ARREADY === 1'b1) break;
            tick();
        end
        check("arready_wait", 64'(ARREADY), 64'd1);
        tick();
        hs_cyc  = cyc;
        ARVALID = 1'b0;
    endtask

    task automatic wait_rvalid(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (RVALID === 1'b1) break;
            tick();
        end
        seen_cyc = cyc;
        check({tag, "_rvalid"}, 64'(RVALID), 64'd1);
    endtask

    task automatic recv_beat(input string tag, input int stall);
        beat_t       e;
        logic [63:0] exp_data;
        logic [63:0] d0;
        logic [1:0]  r0;
        logic        l0;
        logic [3:0]  i0;
        wait_rvalid(tag);
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_unexpected_beat: observed beat expected none", tag);
            return;
        end
        e        = sb.pop_front();
        exp_data = (e.resp == 2'b00) ? mem_word(e.addr & ~64'd7) : 64'd0;
        check({tag, "_rid"},   64'(RID),   64'(e.id));
        check({tag, "_rresp"}, 64'(RRESP), 64'(e.resp));
        check({tag, "_rlast"}, 64'(RLAST), 64'(e.last));
        check({tag, "_rdata"}, RDATA, exp_data);
        check({tag, "_arready_busy"}, 64'(ARREADY), 64'd0);
        if (e.resp == 2'b00) begin
            check({tag, "_memread"}, 64'(mem_log.size()), 64'd1);
            if (mem_log.size() != 0)
                check({tag, "_mem_addr"}, mem_log.pop_front(), e.addr & ~64'd7);
        end else begin
            check({tag, "_no_memread"}, 64'(mem_log.size()), 64'd0);
        end
        d0 = RDATA; r0 = RRESP; l0 = RLAST; i0 = RID;
        for (int k = 0; k < stall; k++) begin
            tick();
            check({tag, "_stall_rvalid"}, 64'(RVALID), 64'd1);
            check({tag, "_stall_rdata"},  RDATA, d0);
            check({tag, "_stall_rresp"},  64'(RRESP), 64'(r0));
            check({tag, "_stall_rlast"},  64'(RLAST), 64'(l0));
            check({tag, "_stall_rid"},    64'(RID), 64'(i0));
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check({tag, "_rvalid_drop"}, 64'(RVALID), 64'd0);
        if (e.last)
            check({tag, "_arready_after_last"}, 64'(ARREADY), 64'd1);
    endtask

    initial begin
        rst     = 1'b1;
        ARID    = '0;
        ARADDR  = '0;
        ARLEN   = '0;
        ARSIZE  = '0;
        ARBURST = '0;
        ARPORT  = 3'b101;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        tick(); tick(); tick();

        check("rst_arready", 64'(ARREADY), 64'd1);
        check("rst_rvalid",  64'(RVALID),  64'd0);
        check("rst_rlast",   64'(RLAST),   64'd0);
        check("rst_rresp",   64'(RRESP),   64'd0);
        check("rst_rdata",   RDATA,        64'd0);
        check("rst_rid",     64'(RID),     64'd0);
        check("rst_mem_ren", 64'(mem_ren), 64'd0);
        check("rst_mem_addr", mem_addr,    64'd0);
        rst = 1'b0;
        tick();

        // INCR single beat, unaligned, with latency check.
        send_ar(4'd3, 64'h8000_0004, 0, 2, 2'b01);
        wait_rvalid("t1_lat");
        check("t1_latency", 64'(seen_cyc - hs_cyc), 64'd2);
        recv_beat("t1", 0);

        // INCR 4 beats with a stall on beat 1.
        send_ar(4'd1, 64'h8000_0010, 3, 3, 2'b01);
        recv_beat("t2b0", 0);
        recv_beat("t2b1", 3);
        recv_beat("t2b2", 0);
        recv_beat("t2b3", 0);

        // WRAP legal and illegal length.
        send_ar(4'd2, 64'h8000_0030, 3, 3, 2'b10);
        for (int b = 0; b < 4; b++) recv_beat("t3a", 0);
        send_ar(4'd2, 64'h8000_0030, 2, 3, 2'b10);
        for (int b = 0; b < 3; b++) recv_beat("t3b", 0);

        // Range and burst-type errors.
        send_ar(4'd4, 64'h87FF_FFF8, 1, 3, 2'b01);
        recv_beat("t4a_b0", 0);
        recv_beat("t4a_b1", 1);
        send_ar(4'd4, 64'h0000_1000, 0, 3, 2'b01);
        recv_beat("t4b", 0);
        send_ar(4'd7, 64'h8000_0000, 0, 3, 2'b11);
        recv_beat("t4c", 0);

        // FIXED burst.
        send_ar(4'd9, 64'h8000_0100, 2, 3, 2'b00);
        for (int b = 0; b < 3; b++) recv_beat("t6", 0);

        // Reset while beat 1 of a 4-beat burst is being presented.
        send_ar(4'd6, 64'h8000_0200, 3, 3, 2'b01);
        recv_beat("t5b0", 0);
        wait_rvalid("t5b1");
        rst = 1'b1;
        #1;
        check("t5_rst_rvalid",  64'(RVALID),  64'd0);
        check("t5_rst_arready", 64'(ARREADY), 64'd1);
        check("t5_rst_mem_ren", 64'(mem_ren), 64'd0);
        sb.delete();
        mem_log.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
        check("t5_arready_release", 64'(ARREADY), 64'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_no_stale_beat", 64'(RVALID), 64'd0);
        end
        check("t5_no_stale_read", 64'(mem_log.size()), 64'd0);
        send_ar(4'd5, 64'h8000_0040, 0, 3, 2'b01);
        recv_beat("t5_new", 0);

        check("end_sb_empty",  64'(sb.size()),      64'd0);
        check("end_mem_empty", 64'(mem_log.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
